// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
package mult_pkg;

    localparam int N_PP  = 8;
    localparam int ACC_W = 32;
    localparam int OP_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        P1,
        P2,
        M1,
        M2
    } booth_mult_e;

    // Radix-4 Booth recoding of one overlapping 3-bit window of the multiplier.
    function automatic booth_mult_e booth_decode(input logic [2:0] digit);
        booth_mult_e m;
        case (digit)
            3'b001, 3'b010: m = P1;
            3'b011:         m = P2;
            3'b100:         m = M2;
            3'b101, 3'b110: m = M1;
            default:        m = ZERO;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/RCA.sv
// 32-bit ripple-carry adder, out = in0 + in1 mod 2^32, no carry in or out.
module RCA (
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    output logic [31:0] out
);

    always_comb begin
        logic c;
        out = '0;
        c   = 1'b0;
        for (int i = 0; i < 32; i++) begin
            out[i] = in0[i] ^ in1[i] ^ c;
            c      = (in0[i] & in1[i]) | (c & (in0[i] ^ in1[i]));
        end
    end

endmodule

// File: rtl/booth_pp_gen.sv
// Booth partial-product generator: selects 0/+-A/+-2A, sign-extends to 32 bits
// and aligns it to the digit position 2*cnt.
module booth_pp_gen
    import mult_pkg::*;
(
    input  logic [OP_W-1:0]  a_r,
    input  logic [2:0]       digit,
    input  logic [2:0]       cnt,
    output logic [ACC_W-1:0] pp
);

    booth_mult_e mult;
    logic [17:0] a_x1;
    logic [17:0] a_x2;
    logic [17:0] multiple;

    // 18 bits are enough to hold -2A for A = -32768 without overflow.
    assign a_x1 = {{2{a_r[OP_W-1]}}, a_r};
    assign a_x2 = {a_r[OP_W-1], a_r, 1'b0};
    assign mult = booth_decode(digit);

    always_comb begin
        case (mult)
            P1:      multiple = a_x1;
            P2:      multiple = a_x2;
            M1:      multiple = ~a_x1 + 18'd1;
            M2:      multiple = ~a_x2 + 18'd1;
            default: multiple = '0;
        endcase
    end

    assign pp = {{(ACC_W-18){multiple[17]}}, multiple} << {cnt, 1'b0};

endmodule

// File: rtl/booth_rca_seq.sv
// Signed 16x16 sequential multiplier: one radix-4 Booth partial product per
// cycle, accumulated through a single shared 32-bit RCA.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   RUN   | accumulating partial product cnt (0..7)
//   DONE  | product held until consumer takes it
module booth_rca_seq
    import mult_pkg::*;
#(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);

    state_e           state;
    logic [OP_W-1:0]  a_r;
    logic [OP_W:0]    b_r;
    logic [ACC_W-1:0] acc;
    logic [2:0]       cnt;
    logic             idle_r;
    logic [2:0]       digit;
    logic [ACC_W-1:0] pp;
    logic [ACC_W-1:0] sum;

    assign digit = b_r[{cnt, 1'b0} +: 3];

    booth_pp_gen u_pp_gen (
        .a_r   (a_r),
        .digit (digit),
        .cnt   (cnt),
        .pp    (pp)
    );

    RCA u_rca (
        .in0 (acc),
        .in1 (pp),
        .out (sum)
    );

    // rst gates in_ready directly so nothing is accepted during the reset cycle
    // while idle_r already reads 1 the cycle after rst falls.
    assign in_ready = idle_r & ~rst;
    assign product  = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            idle_r    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r    <= a;
                        b_r    <= {b, 1'b0};
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                        busy   <= 1'b1;
                        idle_r <= 1'b0;
                    end
                end
                RUN: begin
                    acc <= sum;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'(N_PP - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        idle_r    <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    idle_r    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_rca_seq.sv
// Scoreboard bench for booth_rca_seq: stimulus pushes expected products,
// a monitor pops and compares them when the DUT presents a result.
module tb_booth_rca_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    typedef struct {
        logic [31:0] exp;
        int          edge_n;
    } item_t;

    item_t       exp_q[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          miscompares = 0;
    bit          rand_rdy = 1'b0;
    logic        prev_ov = 1'b0;
    logic [31:0] prev_p = '0;

    booth_rca_seq #(.W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] ev);
        in_valid = 1'b1;
        a = av;
        b = bv;
        for (int k = 0; k < 3000; k++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        if (!in_ready)
            check("accept_timeout", {31'b0, in_ready}, 32'd1);
        else
            exp_q.push_back('{ev, cyc + 1});
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    task automatic drain();
        for (int k = 0; k < 5000; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    // Monitor samples just after the falling edge so driver updates have settled.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_ov = 1'b0;
                continue;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", {31'b0, out_valid}, 32'd0);
                end else begin
                    if (!prev_ov)
                        check("latency", 32'(cyc - exp_q[0].edge_n), 32'd8);
                    else
                        check("hold_stable", product, prev_p);
                    if (out_ready) begin
                        check("product", product, exp_q[0].exp);
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_ov = out_valid;
            prev_p  = product;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] dir_a [6] = '{16'h0000, 16'h0003, 16'h1234, 16'h8000, 16'h7FFF, 16'h7FFF};
    logic [15:0] dir_b [6] = '{16'h0000, 16'hFFFB, 16'h0002, 16'h8000, 16'h8000, 16'h7FFF};
    logic [31:0] dir_p [6] = '{32'h00000000, 32'hFFFFFFF1, 32'h00002468,
                               32'h40000000, 32'hC0008000, 32'h3FFF0001};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_product", product, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            send(dir_a[i], dir_b[i], dir_p[i]);
            drain();
        end

        // Backpressure: 100 * -200 held in DONE while new operands wait.
        out_ready = 1'b0;
        send(16'd100, 16'hFF38, 32'hFFFFB1E0);
        for (int k = 0; k < 50; k++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        in_valid = 1'b1;
        a = 16'h0011;
        b = 16'h0022;
        repeat (5) begin
            @(negedge clk);
            #1;
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_busy", {31'b0, busy}, 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("bp_idle_in_ready", {31'b0, in_ready}, 32'd1);
        send(16'h0011, 16'h0022, 32'h00000242);
        out_ready = 1'b1;
        drain();

        // Reset while cnt = 4: aborted result must never appear.
        send(16'd1234, 16'd5678, 32'h006AE9BC);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_busy", {31'b0, busy}, 32'd0);
        repeat (12) begin
            @(negedge clk);
            #1;
            check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        end
        send(16'd7, 16'hFFF7, 32'hFFFFFFC1);
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] av;
            logic [15:0] bv;
            int ra;
            int rb;
            av = 16'($urandom);
            bv = 16'($urandom);
            ra = int'($signed(av));
            rb = int'($signed(bv));
            send(av, bv, 32'(ra * rb));
        end
        drain();
        rand_rdy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule
